// File: rtl/diff_rx_pkg.sv
// Shared types and defaults for the differential receiver sequencer.
// DIFF_RX_CAL_AVG_EN selects 2-of-3 majority sampling per calibration step.
package diff_rx_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_BIAS = 2'd1,
        ST_CAL  = 2'd2,
        ST_RUN  = 2'd3
    } rx_state_t;

    localparam int TRIM_W_DEF       = 6;
    localparam int BIAS_WAIT_DEF    = 64;
    localparam int CAL_SETTLE_DEF   = 8;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int IDLE_TIMEOUT_DEF = 255;

`ifdef DIFF_RX_CAL_AVG_EN
    localparam int CAL_SAMPLES = 3;
`else
    localparam int CAL_SAMPLES = 1;
`endif

    // Cycles spent on one trim bit: settling plus the sample window.
    function automatic int cal_step_len(input int settle);
        return settle + CAL_SAMPLES;
    endfunction

endpackage

// File: rtl/diff_rx_sync.sv
// Multi-stage bit synchroniser for asynchronous analog flags; clears to 0 on reset.
module diff_rx_sync
    import diff_rx_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/diff_rx_ctrl.sv
// Receiver sequencer: bias power-up, SAR offset trim calibration, then run-mode data/edge/idle.
// Build with DIFF_RX_CAL_AVG_EN to take a 2-of-3 majority of comparator samples per trim bit.
module diff_rx_ctrl
    import diff_rx_pkg::*;
#(
    parameter int TRIM_W       = TRIM_W_DEF,
    parameter int BIAS_WAIT    = BIAS_WAIT_DEF,
    parameter int CAL_SETTLE   = CAL_SETTLE_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              recal_i,
    input  logic              cmp_i,
    output logic              bias_en_o,
    output logic              short_o,
    output logic [TRIM_W-1:0] trim_o,
    output logic              cal_done_o,
    output logic              rx_data_o,
    output logic              rx_edge_o,
    output logic              idle_o
);

    localparam int STEP    = cal_step_len(CAL_SETTLE);
    localparam int CNT_MAX = (BIAS_WAIT > STEP) ? BIAS_WAIT : STEP;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int KW      = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int IW      = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TRIM_W-1:0] TRIM_MSB = {1'b1, {(TRIM_W-1){1'b0}}};

    rx_state_t         state, state_nx;
    logic [CW-1:0]     cnt;
    logic [KW-1:0]     bit_k;
    logic [TRIM_W-1:0] trim_q;
    logic [IW-1:0]     idle_cnt;
    logic              cmp_s, rx_q, edge_q;
    logic              bias_done, step_last, decide;

    diff_rx_sync #(.STAGES(SYNC_STAGES)) u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_i),
        .q   (cmp_s)
    );

    assign bias_done = (state == ST_BIAS) && (cnt == CW'(BIAS_WAIT - 1));
    assign step_last = (state == ST_CAL)  && (cnt == CW'(STEP - 1));

`ifdef DIFF_RX_CAL_AVG_EN
    logic [1:0] votes;

    // Earlier samples of the window accumulate; the last one is folded in combinationally.
    always_ff @(posedge clk) begin
        if (rst || state != ST_CAL || step_last) votes <= '0;
        else if (cnt >= CW'(CAL_SETTLE))          votes <= votes + {1'b0, cmp_s};
    end

    assign decide = ({1'b0, votes} + {2'b00, cmp_s}) >= 3'd2;
`else
    assign decide = cmp_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_OFF;
        else     state <= state_nx;
    end

    // Power-down outranks everything, including a trim step finishing this cycle.
    always_comb begin
        state_nx = state;
        if (!en_i) begin
            state_nx = ST_OFF;
        end else begin
            case (state)
                ST_OFF:  state_nx = ST_BIAS;
                ST_BIAS: if (bias_done) state_nx = ST_CAL;
                ST_CAL:  if (step_last && bit_k == '0) state_nx = ST_RUN;
                ST_RUN:  if (recal_i) state_nx = ST_CAL;
                default: state_nx = ST_OFF;
            endcase
        end
    end

    always_comb begin
        bias_en_o  = 1'b0;
        short_o    = 1'b0;
        cal_done_o = 1'b0;
        rx_data_o  = 1'b0;
        rx_edge_o  = 1'b0;
        idle_o     = 1'b0;
        case (state)
            ST_BIAS: bias_en_o = 1'b1;
            ST_CAL: begin
                bias_en_o = 1'b1;
                short_o   = 1'b1;
            end
            ST_RUN: begin
                bias_en_o  = 1'b1;
                cal_done_o = 1'b1;
                rx_data_o  = rx_q;
                rx_edge_o  = edge_q;
                idle_o     = (idle_cnt == IW'(IDLE_TIMEOUT));
            end
            default: ;
        endcase
    end

    // Phase counter and successive-approximation trim register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            bit_k  <= '0;
            trim_q <= '0;
        end else begin
            if (state_nx != state || step_last)       cnt <= '0;
            else if (state == ST_BIAS || state == ST_CAL) cnt <= cnt + 1'b1;

            if (state != ST_CAL && state_nx == ST_CAL) begin
                trim_q <= TRIM_MSB;
                bit_k  <= KW'(TRIM_W - 1);
            end else if (step_last && en_i) begin
                trim_q[bit_k] <= decide;
                if (bit_k != '0) begin
                    trim_q[bit_k - 1'b1] <= 1'b1;
                    bit_k                <= bit_k - 1'b1;
                end
            end
        end
    end

    // Run-mode receive path; edge and idle-clear are taken from the value about to be captured.
    always_ff @(posedge clk) begin
        if (rst || state != ST_RUN) begin
            rx_q     <= 1'b0;
            edge_q   <= 1'b0;
            idle_cnt <= '0;
        end else begin
            rx_q   <= cmp_s;
            edge_q <= (cmp_s != rx_q);
            if (cmp_s != rx_q)                       idle_cnt <= '0;
            else if (idle_cnt != IW'(IDLE_TIMEOUT))  idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign trim_o = trim_q;

endmodule

// File: doc/diff_rx_ctrl.md
Name: diff_rx_ctrl

Overview:
Digital sequencer for the analog differential receiver macro. Powers up the receiver bias, runs a successive-approximation offset calibration of the comparator trim DAC with the inputs shorted, then releases the receiver into run mode. In run mode it delivers synchronised receive data with edge and idle indications. Sits between the top-level ui_in/uo_out wiring and the analog macro's enable, short and trim pins.

Parameters:
TRIM_W, 6, width of the comparator offset trim DAC code
BIAS_WAIT, 64, bias settling time in clk cycles (>=1)
CAL_SETTLE, 8, cycles waited after each trim trial before sampling (must be >= SYNC_STAGES)
SYNC_STAGES, 2, flip-flop stages in the comparator-output synchroniser (>=2)
IDLE_TIMEOUT, 255, cycles without a data edge before idle_o asserts

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en_i  in  1  level; 1 = receiver enabled, 0 = power down
recal_i  in  1  one-cycle pulse; request recalibration while in RUN
cmp_i  in  1  asynchronous comparator output from analog macro
bias_en_o  out  1  analog bias enable
short_o  out  1  shorts receiver inputs for calibration
trim_o  out  TRIM_W  comparator offset trim code
cal_done_o  out  1  calibration complete, receiver in RUN
rx_data_o  out  1  synchronised receive data (valid in RUN only, else 0)
rx_edge_o  out  1  one-cycle pulse on each rx_data_o change
idle_o  out  1  no edge for IDLE_TIMEOUT cycles in RUN

Behaviour:
- Reset: state OFF; all outputs 0; trim_o = 0; synchroniser flops and counters cleared.
- cmp_i passes through SYNC_STAGES flops -> cmp_s; all decisions use cmp_s only.
- States: OFF, BIAS, CAL, RUN.
- OFF: outputs 0 except trim_o (holds last value). en_i=1 -> BIAS next cycle.
- BIAS: bias_en_o=1; counter runs BIAS_WAIT cycles, then -> CAL.
- CAL: bias_en_o=1, short_o=1. Bit index k from TRIM_W-1 down to 0. Step start: trim_o bit k set to 1, lower bits 0, higher bits keep decided values. Wait CAL_SETTLE cycles, then one sample cycle: cmp_s=1 keeps bit k, cmp_s=0 clears it. Step = CAL_SETTLE+1 cycles. After bit 0 -> RUN. Total CAL = TRIM_W*(CAL_SETTLE+1) cycles.
- Timing: en_i sampled high at edge N -> bias_en_o high from N+1, short_o from N+1+BIAS_WAIT, cal_done_o from N+1+BIAS_WAIT+TRIM_W*(CAL_SETTLE+1) (defaults: N+119).
- RUN: bias_en_o=1, short_o=0, cal_done_o=1, trim_o frozen. rx_data_o = cmp_s registered (1 cycle). rx_edge_o=1 for the cycle in which rx_data_o differs from its previous value. Idle counter clears on edge and saturates at IDLE_TIMEOUT; idle_o=1 while saturated. Counter and idle_o clear on entering RUN.
- recal_i in RUN -> CAL next cycle (bias stays on, no BIAS wait); cal_done_o, rx_*, idle_o drop to 0; trim restarts from MSB. recal_i outside RUN ignored.
- en_i=0 in any state -> OFF next cycle; priority over recal_i and over a step completing in the same cycle. Partial calibration abandoned; trim_o holds partial value.
- rst mid-operation: immediate return to reset values at next edge.

Optional Feature:
DIFF_RX_CAL_AVG_EN: when defined, each CAL step samples cmp_s on 3 consecutive cycles after settling and uses the 2-of-3 majority. Step = CAL_SETTLE+3 cycles (defaults: cal_done_o at N+131). When undefined, single sample as above.

Decomposition:
- Package diff_rx_pkg: state enum (OFF, BIAS, CAL, RUN), default parameter constants, CAL step length function of CAL_SETTLE and macro.
- One sub-module: diff_rx_sync (SYNC_STAGES-deep bit synchroniser, reset to 0), reused for other async analog flags.

Test Plan:
- Comparator model cmp_i = (trim_o <= 37), en_i=1 at edge N -> trim_o=37, cal_done_o rises exactly at N+119; short_o high for N+65..N+118.
- Model target 0 and 63 -> trim_o=0 and 63 respectively (boundary codes).
- In RUN toggle cmp_i every 10 cycles -> rx_data_o follows with SYNC_STAGES+1 latency, one rx_edge_o pulse per toggle; hold static 256 cycles -> idle_o=1 at 255th cycle after last edge, clears on next edge.
- en_i=0 during CAL bit 3 -> next cycle OFF, bias_en_o=short_o=0, trim_o holds partial; en_i=1 again -> full BIAS wait repeated.
- recal_i pulse in RUN with model target changed to 12 -> cal_done_o low next cycle, trim_o=12 and cal_done_o high 54 cycles later; simultaneous en_i=0 -> OFF wins.
- DIFF_RX_CAL_AVG_EN defined, model with one-cycle glitch on each sample window -> majority still yields 37, cal_done_o at N+131.
